// File: rtl/pwm_duty_meter.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_meter
// Purpose  : Measures the duty cycle of an external PWM waveform over one full
//            period (rising edge to rising edge). A sequential divide then
//            reports the result as a value from 0 to 100.
//            If no edge arrives for 2^CW-1 cycles, the output reports 0 or 100
//            depending on the current input level, and stuck is raised.
// Ports    : clk    - system clock, rising edge
//            rst    - synchronous active-high reset
//            ena    - enable; low aborts a measurement and holds the results
//            pwm_in - asynchronous PWM input
//            Npwm   - last measured duty, 0..100
//            valid  - one-cycle pulse when Npwm is updated
//            stuck  - last result came from a timeout (no edges)
// Options  : PWM_DUTY_METER_GLITCH_FILTER_EN - adds a 3-sample majority filter
//            after the synchronizer. It rejects single-cycle glitches and adds
//            one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_meter #(
    parameter int CW = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       pwm_in,
    output logic [6:0] Npwm,
    output logic       valid,
    output logic       stuck
);

    // Dividend hi*100 + per/2 needs CW+7 bits; one quotient bit per cycle.
    localparam int              c_DW      = CW + 7;
    localparam int              c_IW      = $clog2(c_DW);
    localparam logic [CW-1:0]   c_MAX     = '1;
    localparam logic [CW-1:0]   c_ONE     = CW'(1);
    localparam logic [c_IW-1:0] c_LAST    = c_IW'(c_DW - 1);
    localparam logic [c_DW-1:0] c_HUNDRED = c_DW'(100);

    localparam logic [1:0] c_S_ARM     = 2'd0;
    localparam logic [1:0] c_S_MEASURE = 2'd1;
    localparam logic [1:0] c_S_DIVIDE  = 2'd2;

    // ------------------------------------------------------------------
    // Input conditioning: synchronizer, optional filter, rise detector
    // ------------------------------------------------------------------
    logic r_sync1, r_sync2, r_s_prev;
    logic w_s, w_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_DUTY_METER_GLITCH_FILTER_EN
    logic r_h1, r_h2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h1 <= 1'b0;
            r_h2 <= 1'b0;
        end else begin
            r_h1 <= r_sync2;
            r_h2 <= r_h1;
        end
    end

    assign w_s = (r_sync2 & r_h1) | (r_sync2 & r_h2) | (r_h1 & r_h2);
`else
    assign w_s = r_sync2;
`endif

    // The edge history keeps running while disabled. When ena returns with
    // the input already high, no false rise is seen.
    always_ff @(posedge clk) begin
        if (rst) r_s_prev <= 1'b0;
        else     r_s_prev <= w_s;
    end

    assign w_rise = w_s & ~r_s_prev;

    // ------------------------------------------------------------------
    // Measurement state and divider datapath
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [CW-1:0]   r_per_cnt;   // period count in MEASURE, idle count in ARM
    logic [CW-1:0]   r_hi_cnt;
    logic [CW-1:0]   r_div;
    logic [c_DW-1:0] r_quo;       // dividend shifted out, quotient shifted in
    logic [CW-1:0]   r_rem;
    logic [c_IW-1:0] r_bit;

    logic [c_DW-1:0] w_dividend;
    logic [CW:0]     w_rem_sh;
    logic [CW-1:0]   w_diff;
    logic            w_qbit;
    logic [CW-1:0]   w_rem_nx;
    logic [c_DW-1:0] w_quo_nx;
    logic [6:0]      w_npwm;

    assign w_dividend = ({7'd0, r_hi_cnt} * c_HUNDRED) + c_DW'(r_per_cnt >> 1);

    // Restoring step. The remainder stays below the divisor, so the CW-bit
    // wrap-around difference is exact whenever the subtraction is taken.
    assign w_rem_sh = {r_rem, r_quo[c_DW-1]};
    assign w_qbit   = (w_rem_sh >= {1'b0, r_div});
    assign w_diff   = w_rem_sh[CW-1:0] - r_div;
    assign w_rem_nx = w_qbit ? w_diff : w_rem_sh[CW-1:0];
    assign w_quo_nx = {r_quo[c_DW-2:0], w_qbit};

    // hi <= per bounds the quotient at 100; clamp defends against anything else.
    assign w_npwm = (w_quo_nx > c_HUNDRED) ? 7'd100 : w_quo_nx[6:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_ARM;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_div     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_bit     <= '0;
            Npwm      <= 7'd0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!ena) begin
                r_state   <= c_S_ARM;
                r_per_cnt <= '0;
                r_hi_cnt  <= '0;
                r_bit     <= '0;
            end else begin
                case (r_state)
                    c_S_ARM: begin
                        if (w_rise) begin
                            // The rise cycle is the first cycle of the period and is high.
                            r_state   <= c_S_MEASURE;
                            r_per_cnt <= c_ONE;
                            r_hi_cnt  <= c_ONE;
                        end else if (r_per_cnt == c_MAX) begin
                            Npwm      <= w_s ? 7'd100 : 7'd0;
                            valid     <= 1'b1;
                            stuck     <= 1'b1;
                            r_per_cnt <= '0;
                            r_hi_cnt  <= '0;
                        end else begin
                            r_per_cnt <= r_per_cnt + c_ONE;
                        end
                    end

                    c_S_MEASURE: begin
                        if (w_rise) begin
                            // The closing rise cycle belongs to the next period.
                            r_div   <= r_per_cnt;
                            r_quo   <= w_dividend;
                            r_rem   <= '0;
                            r_bit   <= '0;
                            r_state <= c_S_DIVIDE;
                        end else if (r_per_cnt == c_MAX) begin
                            Npwm      <= w_s ? 7'd100 : 7'd0;
                            valid     <= 1'b1;
                            stuck     <= 1'b1;
                            r_state   <= c_S_ARM;
                            r_per_cnt <= '0;
                            r_hi_cnt  <= '0;
                        end else begin
                            r_per_cnt <= r_per_cnt + c_ONE;
                            if (w_s) r_hi_cnt <= r_hi_cnt + c_ONE;
                        end
                    end

                    c_S_DIVIDE: begin
                        r_quo <= w_quo_nx;
                        r_rem <= w_rem_nx;
                        r_bit <= r_bit + c_IW'(1);
                        if (r_bit == c_LAST) begin
                            Npwm      <= w_npwm;
                            valid     <= 1'b1;
                            stuck     <= 1'b0;
                            r_state   <= c_S_ARM;
                            r_per_cnt <= '0;
                            r_hi_cnt  <= '0;
                        end
                    end

                    default: r_state <= c_S_ARM;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_duty_meter
// Purpose  : Self-checking bench for pwm_duty_meter. PWM waveforms are built as
//            per-cycle sample arrays. A reference model works out from each
//            array which periods get measured and what duty each one reports.
//            The DUT's valid results are collected and compared to that model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_meter;

    localparam int CW    = 12;
    localparam int c_MAX = (1 << CW) - 1;
`ifdef PWM_DUTY_METER_GLITCH_FILTER_EN
    localparam int c_SYNC = 3;
`else
    localparam int c_SYNC = 2;
`endif
    // Edges from a driven closing rise to the sampled valid pulse.
    localparam int c_LAT = c_SYNC + CW + 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       pwm_in;
    logic [6:0] Npwm;
    logic       valid;
    logic       stuck;

    pwm_duty_meter #(.CW(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .pwm_in (pwm_in),
        .Npwm   (Npwm),
        .valid  (valid),
        .stuck  (stuck)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_dbl  = 0;
    bit         wave[$];
    int         exp_q[$];
    logic [7:0] dut_q[$];
    logic       r_prev_valid = 1'b0;

    // Result collector, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid) dut_q.push_back({stuck, Npwm});
        if (valid && r_prev_valid) n_dbl++;
        r_prev_valid <= valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_seg(input bit v, input int n);
        repeat (n) wave.push_back(v);
    endtask

    task automatic restart();
        pwm_in = 1'b0;
        ena    = 1'b0;
        repeat (5) tick();
        ena = 1'b1;
        repeat (3) tick();
        dut_q.delete();
    endtask

    task automatic play();
        foreach (wave[i]) begin
            pwm_in = wave[i];
            tick();
        end
    endtask

    // Reference: a rise opens a period only if the meter is armed. The next
    // rise closes it. The meter is busy dividing for CW+7 cycles afterwards,
    // and any rise in that window is ignored.
    task automatic model_run();
        bit s[$];
        bit a, b, c, prev;
        int open_t, ready, hi, per;
        exp_q.delete();
        for (int i = 0; i < wave.size(); i++) begin
            a = wave[i];
            b = (i > 0) ? wave[i-1] : 1'b0;
            c = (i > 1) ? wave[i-2] : 1'b0;
`ifdef PWM_DUTY_METER_GLITCH_FILTER_EN
            s.push_back((a & b) | (a & c) | (b & c));
`else
            s.push_back(a);
`endif
        end
        open_t = -1;
        ready  = 0;
        for (int i = 0; i < s.size(); i++) begin
            prev = (i > 0) ? s[i-1] : 1'b0;
            if (s[i] && !prev) begin
                if (open_t >= 0) begin
                    hi  = 0;
                    per = i - open_t;
                    for (int j = open_t; j < i; j++) hi += int'(s[j]);
                    exp_q.push_back((hi * 100 + per / 2) / per);
                    open_t = -1;
                    ready  = i + CW + 8;
                end else if (i >= ready) begin
                    open_t = i;
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, dut_q.size(), exp_q.size());
        for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_npwm"}, dut_q[i][6:0], exp_q[i]);
            chk({tag, "_stuck"}, dut_q[i][7], 0);
        end
    endtask

    task automatic go(input string tag);
        restart();
        model_run();
        play();
        compare(tag);
    endtask

    task automatic run_wave(input int h, input int p, input int n, input string tag);
        wave.delete();
        repeat (n) begin
            add_seg(1'b1, h);
            add_seg(1'b0, p - h);
        end
        add_seg(1'b0, 40);
        go(tag);
    endtask

    task automatic wait_valid(output int cycles, input int limit);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, p, h, first;

        // Reset state
        rst = 1'b1; ena = 1'b0; pwm_in = 1'b0;
        repeat (3) tick();
        chk("rst_npwm", Npwm, 0);
        chk("rst_valid", valid, 0);
        chk("rst_stuck", stuck, 0);
        rst = 1'b0;

        // Closing-rise-to-valid latency, 30% duty
        restart();
        pwm_in = 1'b1; repeat (30) tick();
        pwm_in = 1'b0; repeat (70) tick();
        pwm_in = 1'b1;
        wait_valid(lat, 60);
        chk("latency", lat, c_LAT);
        chk("lat_npwm", Npwm, 30);
        chk("lat_stuck", stuck, 0);

        run_wave(300, 700, 4, "p30");
        run_wave(1, 3, 6, "p3h1");
        run_wave(2, 3, 6, "p3h2");

        for (int k = 0; k < 6; k++) begin
            p = $urandom_range(400, 2);
            h = $urandom_range(p - 1, 1);
            run_wave(h, p, 4, "rnd");
        end

        // Timeouts: input held low, then held high
        pwm_in = 1'b0; ena = 1'b0; repeat (5) tick(); ena = 1'b1;
        wait_valid(lat, c_MAX + 20);
        chk("to_low_time", lat, c_MAX + 1);
        chk("to_low_npwm", Npwm, 0);
        chk("to_low_stuck", stuck, 1);

        pwm_in = 1'b1; ena = 1'b0; repeat (5) tick(); ena = 1'b1;
        wait_valid(lat, c_MAX + 20);
        chk("to_high_time", lat, c_MAX + 1);
        chk("to_high_npwm", Npwm, 100);
        chk("to_high_stuck", stuck, 1);

        run_wave(100, 200, 4, "p50");

        // Reset in the middle of a divide
        restart();
        pwm_in = 1'b1; repeat (60) tick();
        pwm_in = 1'b0; repeat (40) tick();
        pwm_in = 1'b1;
        repeat (c_SYNC + 10) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_npwm", Npwm, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_stuck", stuck, 0);
        rst = 1'b0;
        dut_q.delete();
        repeat (40) tick();
        chk("mid_rst_stale", dut_q.size(), 0);
        run_wave(25, 100, 4, "post_rst");

        // Enable dropped mid-measurement; Npwm must hold the prior 25
        dut_q.delete();
        pwm_in = 1'b1; repeat (100) tick();
        ena = 1'b0;
        repeat (50) tick();
        chk("ena_hold", Npwm, 25);
        chk("ena_novalid", dut_q.size(), 0);
        ena = 1'b1;
        repeat (50) tick();
        pwm_in = 1'b0; repeat (300) tick();
        wave.delete();
        repeat (3) begin
            add_seg(1'b1, 200);
            add_seg(1'b0, 300);
        end
        add_seg(1'b0, 40);
        dut_q.delete();
        play();
        chk("ena_some", (dut_q.size() >= 1), 1);
        foreach (dut_q[i]) chk("ena_npwm", dut_q[i][6:0], 40);

        // Single-cycle glitch inside the high phase of a 40% waveform
        wave.delete();
        repeat (4) begin
            add_seg(1'b1, 100);
            add_seg(1'b0, 1);
            add_seg(1'b1, 99);
            add_seg(1'b0, 300);
        end
        add_seg(1'b0, 40);
        go("glitch");
        first = (dut_q.size() > 0) ? int'(dut_q[0][6:0]) : -1;
`ifdef PWM_DUTY_METER_GLITCH_FILTER_EN
        chk("glitch_filtered", first, 40);
`else
        chk("glitch_differs", (first != 40), 1);
`endif

        chk("no_double_valid", n_dbl, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
